// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - shared types and constants for the DES mode controller
//
// Purpose: state encoding, mode/chaining constants and block width shared by
// des_mode_ctrl and des_chain_reg.
// Ports: none (package).

package des_pkg;

  localparam int DES_BLK_W = 64;

  localparam logic MODE_ENC  = 1'b0;
  localparam logic MODE_DEC  = 1'b1;
  localparam logic CHAIN_ECB = 1'b0;
  localparam logic CHAIN_CBC = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    WAIT,
    OUT,
    GAP
  } state_t;

  // Conditional 64-bit whitening used on both sides of the core.
  function automatic logic [DES_BLK_W-1:0] xor_if(
    input logic                 en,
    input logic [DES_BLK_W-1:0] a,
    input logic [DES_BLK_W-1:0] b
  );
    return en ? (a ^ b) : a;
  endfunction

endpackage

// File: rtl/des_chain_reg.sv
// rtl/des_chain_reg.sv - IV/chain register with pre- and post-core XOR select
//
// Purpose: holds the CBC chain value, loads it from the IV, advances it when a
// core result is captured, and forms the data words entering and leaving the
// core.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   iv_load         IV load strobe (already qualified with IDLE by the parent)
//   iv_din          initial vector
//   acc_data        block being accepted this cycle
//   acc_cbc         chaining mode of the block being accepted
//   acc_decrypt     direction of the block being accepted
//   acc_din         word to register into core_din at accept
//   capture         core result is being captured this cycle
//   blk_cbc         latched chaining mode of the block in flight
//   blk_decrypt     latched direction of the block in flight
//   blk_data        latched input block of the block in flight
//   core_dout       core result
//   result          word to register into out_data at capture

module des_chain_reg
  import des_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iv_load,
  input  logic [DES_BLK_W-1:0] iv_din,
  input  logic [DES_BLK_W-1:0] acc_data,
  input  logic                 acc_cbc,
  input  logic                 acc_decrypt,
  output logic [DES_BLK_W-1:0] acc_din,
  input  logic                 capture,
  input  logic                 blk_cbc,
  input  logic                 blk_decrypt,
  input  logic [DES_BLK_W-1:0] blk_data,
  input  logic [DES_BLK_W-1:0] core_dout,
  output logic [DES_BLK_W-1:0] result
);

  logic [DES_BLK_W-1:0] chain;
  logic [DES_BLK_W-1:0] chain_eff;
  logic                 pre_xor;
  logic                 post_xor;

  // An IV load in the same cycle as an accept must feed the new IV straight
  // into the XOR, so bypass the register here.
  assign chain_eff = iv_load ? iv_din : chain;

  assign pre_xor  = (acc_cbc == CHAIN_CBC) && (acc_decrypt == MODE_ENC);
  assign post_xor = (blk_cbc == CHAIN_CBC) && (blk_decrypt == MODE_DEC);

  assign acc_din = xor_if(pre_xor, acc_data, chain_eff);
  assign result  = xor_if(post_xor, core_dout, chain);

  // iv_load only happens in IDLE and capture only in WAIT, so they never
  // compete; the priority order is just for readability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else if (iv_load) begin
      chain <= iv_din;
    end else if (capture && (blk_cbc == CHAIN_CBC)) begin
      chain <= (blk_decrypt == MODE_DEC) ? blk_data : core_dout;
    end
  end

endmodule

// File: rtl/des_mode_ctrl.sv
// rtl/des_mode_ctrl.sv - ECB/CBC block-stream front end for an iterative DES core
//
// Purpose: accepts one 64-bit block at a time, applies ECB or CBC chaining,
// runs one DES core operation per block and returns the result through a
// one-entry output register with valid/ready backpressure.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_cbc, cfg_decrypt       chaining mode and direction, sampled at accept
//   cfg_key                    DES key, sampled at accept
//   iv_load, iv_din            IV load pulse and value (honoured in IDLE only)
//   in_valid, in_ready, in_data   input block handshake
//   out_valid, out_ready, out_data  result handshake
//   core_din, core_key, core_mode, core_start   request to the DES core
//   core_dout, core_valid      result from the DES core (valid is a level)
//   busy                       high whenever not IDLE
//   err_timeout                sticky core timeout flag, cleared on accept

module des_mode_ctrl
  import des_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int GAP_CYC     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_cbc,
  input  logic                 cfg_decrypt,
  input  logic [DES_BLK_W-1:0] cfg_key,
  input  logic                 iv_load,
  input  logic [DES_BLK_W-1:0] iv_din,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DES_BLK_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DES_BLK_W-1:0] out_data,
  output logic [DES_BLK_W-1:0] core_din,
  output logic [DES_BLK_W-1:0] core_key,
  output logic                 core_mode,
  output logic                 core_start,
  input  logic [DES_BLK_W-1:0] core_dout,
  input  logic                 core_valid,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = 4;

  state_t state;
  state_t state_nxt;

  logic [TMR_W-1:0]     tmr;
  logic [GAP_W-1:0]     gap_cnt;
  logic [DES_BLK_W-1:0] blk_data;
  logic                 blk_cbc;
  logic                 blk_decrypt;

  logic                 accept;
  logic                 iv_take;
  logic                 capture;
  logic                 tmr_hit;
  logic                 timeout;
  logic                 gap_done;
  logic [DES_BLK_W-1:0] acc_din;
  logic [DES_BLK_W-1:0] result;

  assign accept   = in_valid && in_ready;
  assign iv_take  = iv_load && in_ready;
  assign capture  = (state == WAIT) && core_valid;
  assign tmr_hit  = (tmr == TMR_W'(TIMEOUT_CYC - 1));
  assign timeout  = (state == WAIT) && !core_valid && tmr_hit;
  assign gap_done = (gap_cnt == GAP_W'(GAP_CYC - 1));

  des_chain_reg u_chain (
    .clk         (clk),
    .rst_n       (rst_n),
    .iv_load     (iv_take),
    .iv_din      (iv_din),
    .acc_data    (in_data),
    .acc_cbc     (cfg_cbc),
    .acc_decrypt (cfg_decrypt),
    .acc_din     (acc_din),
    .capture     (capture),
    .blk_cbc     (blk_cbc),
    .blk_decrypt (blk_decrypt),
    .blk_data    (blk_data),
    .core_dout   (core_dout),
    .result      (result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    core_start = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = SETUP;
        end
      end
      // core_din/key/mode were registered at accept; this cycle lets the core
      // sample mode before it sees start.
      SETUP: state_nxt = START;
      START: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (core_valid) begin
          state_nxt = OUT;
        end else if (tmr_hit) begin
          state_nxt = GAP;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // WAIT timer: cleared in START, saturates at TIMEOUT_CYC-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (state == START) begin
      tmr <= '0;
    end else if ((state == WAIT) && !core_valid && !tmr_hit) begin
      tmr <= tmr + 1'b1;
    end
  end

  // Gap counter: zero outside GAP, counts GAP_CYC cycles inside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else if (state != GAP) begin
      gap_cnt <= '0;
    end else if (!gap_done) begin
      gap_cnt <= gap_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_data    <= '0;
      blk_cbc     <= CHAIN_ECB;
      blk_decrypt <= MODE_ENC;
      core_din    <= '0;
      core_key    <= '0;
      core_mode   <= MODE_ENC;
    end else if (accept) begin
      blk_data    <= in_data;
      blk_cbc     <= cfg_cbc;
      blk_decrypt <= cfg_decrypt;
      core_din    <= acc_din;
      core_key    <= cfg_key;
      core_mode   <= cfg_decrypt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= result;
    end else if ((state == OUT) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
    end else if (accept) begin
      err_timeout <= 1'b0;
    end else if (timeout) begin
      err_timeout <= 1'b1;
    end
  end

endmodule

// File: doc/des_mode_ctrl.md
Name: des_mode_ctrl

Overview:
- Block-stream front end for the iterative 64-bit DES core.
- Accepts plaintext or ciphertext blocks over a valid/ready handshake and applies ECB or CBC chaining.
- Launches one core operation per block: drives data, key and mode, pulses start, then waits for the core's valid.
- Returns the result through a one-entry output register with valid/ready backpressure.
- Sits directly upstream of the DES core and also consumes the core's output.

Parameters:
- TIMEOUT_CYC, 64, cycles to wait in WAIT for the core's valid before raising err_timeout.
- GAP_CYC, 2, minimum cycles core_start is held low after each operation (lets the core's counter clear); legal range 2..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_cbc  in  1  0 = ECB, 1 = CBC; sampled at block accept.
- cfg_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled at block accept.
- cfg_key  in  64  DES key; sampled at block accept.
- iv_load  in  1  one-cycle pulse that loads iv_din into the chain register; honoured only in IDLE.
- iv_din  in  64  initial vector.
- in_valid  in  1  input block valid.
- in_ready  out  1  high only in IDLE.
- in_data  in  64  input block.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_data  out  64  result block.
- core_din  out  64  data to the core.
- core_key  out  64  key to the core.
- core_mode  out  1  0 = encrypt, 1 = decrypt.
- core_start  out  1  one-cycle start pulse.
- core_dout  in  64  core result.
- core_valid  in  1  core result valid (level).
- busy  out  1  high whenever state is not IDLE.
- err_timeout  out  1  sticky error flag; cleared by the next accepted block.

Behaviour:
- Reset values: all outputs 0, except in_ready = 1. Chain register = 0. State = IDLE.
- IDLE:
  - in_valid & in_ready accepts a block and latches data, cfg_cbc, cfg_decrypt and cfg_key.
  - core_din is registered at accept:
    - ECB: in_data.
    - CBC encrypt: in_data ^ chain.
    - CBC decrypt: in_data.
  - Next state: SETUP.
  - iv_load in IDLE: chain <= iv_din. If iv_load and an accept occur in the same cycle, the accepted block's XOR uses iv_din, not the old chain value.
- SETUP, 1 cycle: core_mode, core_key and core_din are stable while core_start = 0 (the core registers mode one cycle before start). Next state: START.
- START, 1 cycle: core_start = 1. Next state: WAIT; the timer is cleared.
- WAIT:
  - On the first cycle core_valid = 1, capture the result into out_data:
    - ECB or CBC encrypt: core_dout.
    - CBC decrypt: core_dout ^ chain.
  - Chain update on capture (CBC only):
    - Encrypt: chain <= core_dout.
    - Decrypt: chain <= latched input ciphertext.
  - On capture: set out_valid and go to OUT.
  - If the timer reaches TIMEOUT_CYC with no core_valid: err_timeout <= 1, no output, chain unchanged, go to GAP.
- OUT: out_valid held with out_data stable until out_ready. On the handshake, out_valid <= 0 in the next cycle and the state goes to GAP.
- GAP: core_start = 0 for GAP_CYC cycles, then IDLE with in_ready = 1. core_valid is ignored in every state except WAIT.
- Throughput: accept to out_valid = 3 + core latency cycles. Minimum block period = 4 + core latency + GAP_CYC cycles.
- Settings in flight: cfg_* and iv_load changes while busy have no effect on the block in flight; iv_load is ignored while busy.
- Reset mid-operation: everything returns to reset values immediately; the chain register is cleared and must be reloaded.
- Arithmetic: all XORs are 64-bit bitwise. No counter may wrap; the timer saturates.

Decomposition:
- Shared package des_pkg:
  - State enum {IDLE, SETUP, START, WAIT, OUT, GAP}.
  - Constants MODE_ENC = 0, MODE_DEC = 1, CHAIN_ECB = 0, CHAIN_CBC = 1.
  - Block width constant DES_BLK_W = 64.
- Sub-module des_chain_reg: holds the IV/chain register and implements the load, update and XOR-select logic.
- The FSM, timers and handshakes stay in the top.

Test Plan:
- ECB encrypt, key 133457799BBCDFF1, in 0123456789ABCDEF -> out_data 85E813540F0AB405. Also check exactly one core_start pulse, with core_mode = 0 one cycle before it.
- ECB decrypt, same key, in 85E813540F0AB405 -> out_data 0123456789ABCDEF.
- CBC encrypt, key 0123456789ABCDEF, IV 1234567890ABCDEF.
  - Input blocks: 4E6F772069732074, 68652074696D6520, 666F7220616C6C20.
  - Required outputs in order: E5C7CDDE872BF27C, 43E934008C389C0F, 683788499A7C05F6.
  - Then reload the IV and CBC-decrypt those three outputs -> the original plaintext.
- Backpressure: out_ready held low for 20 cycles -> out_valid and out_data stable, in_ready = 0, core_start = 0 throughout. Then release -> exactly one handshake, and core_start stays low for GAP_CYC cycles.
- Timeout: core model never asserts core_valid -> err_timeout = 1 after TIMEOUT_CYC WAIT cycles, out_valid never rises, chain unchanged. The next valid block clears err_timeout and completes correctly.
- rst_n asserted in WAIT mid-CBC -> outputs return to reset values asynchronously and in_ready = 1 after release. A new block without iv_load chains from IV 0.
